// File: rtl/uart_port_arbiter.sv
// Sole master of the UART register port: polls status, sends bytes from up to
// eight round-robin requesters, and drains received bytes into a one-byte buffer.
module uart_port_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   tx_valid,
  input  logic [8*N_REQ-1:0] tx_data,
  output logic [N_REQ-1:0]   tx_ready,
  output logic               rx_valid,
  output logic [7:0]         rx_data,
  input  logic               rx_ready,
  output logic               busy,
  output logic [2:0]         uart_a,
  output logic [31:0]        uart_d,
  output logic               uart_we,
  input  logic [31:0]        uart_spo
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX_RD,
    S_RX_CLR,
    S_TX_CHK,
    S_TX_WR,
    S_TX_GAP
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            r_rxValid;
  logic [7:0]      r_rxData;
  logic [GW-1:0]   r_lastGrant;
  logic [7:0]      r_txByte;
  logic [GW-1:0]   w_grant;
  logic [GW-1:0]   w_cand;
  logic            w_found;
  logic            w_latch;
  logic [7:0]      w_grantByte;
  int              w_sum;
  logic            w_unusedSpo;

  assign w_unusedSpo = ^uart_spo[23:0];

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_grant = r_lastGrant;
    w_found = 1'b0;
    w_sum   = 0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_sum = int'(r_lastGrant) + k;
      if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
      w_cand = GW'(w_sum);
      if (!w_found && tx_valid[w_cand]) begin
        w_found = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  always_comb begin
    w_grantByte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant == GW'(i)) w_grantByte = tx_data[i*8 +: 8];
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_latch     = 1'b0;
    uart_a      = 3'd1;
    uart_we     = 1'b0;
    uart_d      = '0;
    case (r_state)
      S_IDLE: begin
        if (uart_spo[24] && !r_rxValid) begin
          w_nextState = S_RX_RD;
        end else if (|tx_valid) begin
          w_nextState = S_TX_CHK;
          w_latch     = 1'b1;
        end
      end
      S_RX_RD: begin
        uart_a      = 3'd0;
        w_nextState = S_RX_CLR;
      end
      S_RX_CLR: begin
        uart_a      = 3'd1;
        uart_we     = 1'b1;
        w_nextState = S_IDLE;
      end
      S_TX_CHK: begin
        uart_a = 3'd2;
        if (uart_spo[24]) w_nextState = S_TX_WR;
      end
      S_TX_WR: begin
        uart_a      = 3'd0;
        uart_we     = 1'b1;
        uart_d      = {r_txByte, 24'h000000};
        w_nextState = S_TX_GAP;
      end
      // Status lags the write by a cycle, so this read is deliberately ignored.
      S_TX_GAP: begin
        uart_a      = 3'd2;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      tx_ready[i] = (r_state == S_TX_WR) && (r_lastGrant == GW'(i));
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign rx_valid = r_rxValid;
  assign rx_data  = r_rxData;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // The byte is captured with the grant so a late-dropping requester still gets it sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastGrant <= GW'(N_REQ - 1);
      r_txByte    <= '0;
    end else if (w_latch) begin
      r_lastGrant <= w_grant;
      r_txByte    <= w_grantByte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxValid <= 1'b0;
      r_rxData  <= '0;
    end else if (r_state == S_RX_RD) begin
      r_rxValid <= 1'b1;
      r_rxData  <= uart_spo[31:24];
    end else if (r_rxValid && rx_ready) begin
      r_rxValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed bench for uart_port_arbiter: a small UART register model, queued
// requesters and hand-computed write order, latency and rx buffer expectations.
module tb_uart_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  tx_valid = '0;
  logic [15:0] tx_data = '0;
  logic [1:0]  tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready = 1'b0;
  logic        busy;
  logic [2:0]  uart_a;
  logic [31:0] uart_d;
  logic        uart_we;
  logic [31:0] uart_spo;

  logic [2:0]  txValid3 = '0;
  logic [23:0] txData3 = '0;
  logic [2:0]  txReady3;
  logic        unusedRxValid3;
  logic [7:0]  unusedRxData3;
  logic        unusedBusy3;
  logic [2:0]  uartA3;
  logic [31:0] uartD3;
  logic        uartWe3;
  logic [31:0] uartSpo3;

  logic        rxNew = 1'b0;
  logic [7:0]  rxByte = '0;
  logic        uartIdle = 1'b1;
  logic        injectValid = 1'b0;
  logic [7:0]  injectByte = '0;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          readyPulses = 0;

  logic [31:0] wrData[$];
  int          wrCyc[$];
  logic [1:0]  wrReady[$];
  int          clrCyc[$];
  logic [7:0]  wr3[$];
  logic [2:0]  wr3Ready[$];
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];

  always #5 clk = ~clk;

  uart_port_arbiter #(.N_REQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .busy(busy), .uart_a(uart_a), .uart_d(uart_d), .uart_we(uart_we),
    .uart_spo(uart_spo)
  );

  uart_port_arbiter #(.N_REQ(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .tx_valid(txValid3), .tx_data(txData3), .tx_ready(txReady3),
    .rx_valid(unusedRxValid3), .rx_data(unusedRxData3), .rx_ready(1'b0),
    .busy(unusedBusy3), .uart_a(uartA3), .uart_d(uartD3), .uart_we(uartWe3),
    .uart_spo(uartSpo3)
  );

  // UART register model: read mux plus rx_new set by injection, cleared by a=1 write.
  always_comb begin
    case (uart_a)
      3'd0:    uart_spo = {rxByte, 24'h000000};
      3'd1:    uart_spo = {7'h00, rxNew, 24'h000000};
      3'd2:    uart_spo = {7'h00, uartIdle, 24'h000000};
      default: uart_spo = 32'h0;
    endcase
  end

  assign uartSpo3 = (uartA3 == 3'd2) ? 32'h0100_0000 : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (injectValid) begin
      rxNew  <= 1'b1;
      rxByte <= injectByte;
    end else if (uart_we && uart_a == 3'd1) begin
      rxNew <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (uart_we && uart_a == 3'd0) begin
        wrData.push_back(uart_d);
        wrCyc.push_back(cyc);
        wrReady.push_back(tx_ready);
      end
      if (uart_we && uart_a == 3'd1) clrCyc.push_back(cyc);
      if (tx_ready != 2'b00) readyPulses <= readyPulses + 1;
      if (uartWe3 && uartA3 == 3'd0) begin
        wr3.push_back(uartD3[31:24]);
        wr3Ready.push_back(txReady3);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic refreshReq();
    tx_valid[0]  = (q0.size() > 0);
    tx_valid[1]  = (q1.size() > 0);
    tx_data[7:0] = (q0.size() > 0) ? q0[0] : 8'h00;
    tx_data[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
  endtask

  // Each requester retires its head byte once it sees its accept pulse.
  task automatic applyStimulus(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      if (tx_ready[0] && q0.size() > 0) q0.delete(0);
      if (tx_ready[1] && q1.size() > 0) q1.delete(0);
      refreshReq();
    end
  endtask

  task automatic applyReset();
    q0.delete();
    q1.delete();
    refreshReq();
    rst_n = 1'b0;
    applyStimulus(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int cb;
    int rb;
    int start;
    logic [7:0] exp2[4];
    logic [1:0] expRdy2[4];
    exp2    = '{8'hA0, 8'hB1, 8'hA0, 8'hB1};
    expRdy2 = '{2'b01, 2'b10, 2'b01, 2'b10};

    #2 rst_n = 1'b0;
    applyStimulus(2);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstUartA", uart_a, 1);
    checkOutput("rstUartWe", uart_we, 0);
    checkOutput("rstUartD", uart_d, 0);
    checkOutput("rstTxReady", tx_ready, 0);
    checkOutput("rstRxValid", rx_valid, 0);
    checkOutput("rstRxData", rx_data, 0);
    rst_n = 1'b1;
    applyStimulus(1);

    $display("[TB] single byte");
    q0.push_back(8'h55);
    refreshReq();
    base = wrData.size(); rb = readyPulses; start = cyc;
    applyStimulus(8);
    checkOutput("t1WriteCount", wrData.size() - base, 1);
    if (wrData.size() > base) begin
      checkOutput("t1Data", wrData[base], 32'h5500_0000);
      checkOutput("t1Latency", wrCyc[base] - start, 2);
      checkOutput("t1Ready", wrReady[base], 2'b01);
    end
    checkOutput("t1ReadyPulses", readyPulses - rb, 1);
    checkOutput("t1Busy", busy, 0);

    $display("[TB] round robin");
    applyReset();
    applyStimulus(1);
    q0.push_back(8'hA0); q0.push_back(8'hA0);
    q1.push_back(8'hB1); q1.push_back(8'hB1);
    refreshReq();
    base = wrData.size(); start = cyc;
    applyStimulus(25);
    checkOutput("t2WriteCount", wrData.size() - base, 4);
    if (wrData.size() >= base + 4) begin
      checkOutput("t2Latency", wrCyc[base] - start, 2);
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("t2Data%0d", i), wrData[base+i], {exp2[i], 24'h000000});
        checkOutput($sformatf("t2Ready%0d", i), wrReady[base+i], expRdy2[i]);
        if (i > 0) checkOutput($sformatf("t2Spacing%0d", i), wrCyc[base+i] - wrCyc[base+i-1], 4);
      end
    end

    $display("[TB] busy uart");
    uartIdle = 1'b0;
    q0.push_back(8'h77);
    refreshReq();
    base = wrData.size();
    applyStimulus(200);
    checkOutput("t3NoWrite", wrData.size() - base, 0);
    checkOutput("t3Busy", busy, 1);
    checkOutput("t3UartA", uart_a, 2);
    uartIdle = 1'b1;
    start = cyc;
    applyStimulus(6);
    checkOutput("t3WriteCount", wrData.size() - base, 1);
    if (wrData.size() > base) begin
      checkOutput("t3Data", wrData[base], 32'h7700_0000);
      checkOutput("t3Latency", wrCyc[base] - start, 1);
    end

    $display("[TB] rx path");
    cb = clrCyc.size();
    injectValid = 1'b1; injectByte = 8'h3C;
    applyStimulus(1);
    injectValid = 1'b0;
    applyStimulus(6);
    checkOutput("t4RxValid", rx_valid, 1);
    checkOutput("t4RxData", rx_data, 8'h3C);
    checkOutput("t4Clears", clrCyc.size() - cb, 1);
    injectValid = 1'b1; injectByte = 8'h4D;
    applyStimulus(1);
    injectValid = 1'b0;
    applyStimulus(10);
    checkOutput("t4HeldData", rx_data, 8'h3C);
    checkOutput("t4HeldValid", rx_valid, 1);
    checkOutput("t4HeldClears", clrCyc.size() - cb, 1);
    checkOutput("t4HeldBusy", busy, 0);
    rx_ready = 1'b1;
    applyStimulus(1);
    rx_ready = 1'b0;
    applyStimulus(6);
    checkOutput("t4SecondValid", rx_valid, 1);
    checkOutput("t4SecondData", rx_data, 8'h4D);
    checkOutput("t4SecondClears", clrCyc.size() - cb, 2);
    rx_ready = 1'b1;
    applyStimulus(1);
    rx_ready = 1'b0;
    checkOutput("t4Drained", rx_valid, 0);

    $display("[TB] rx/tx collision");
    injectValid = 1'b1; injectByte = 8'h5A;
    applyStimulus(1);
    injectValid = 1'b0;
    q0.push_back(8'h99);
    refreshReq();
    base = wrData.size(); cb = clrCyc.size(); start = cyc;
    applyStimulus(10);
    checkOutput("t5Clears", clrCyc.size() - cb, 1);
    if (clrCyc.size() > cb) checkOutput("t5ClearCycle", clrCyc[cb] - start, 2);
    checkOutput("t5WriteCount", wrData.size() - base, 1);
    if (wrData.size() > base) begin
      checkOutput("t5WriteCycle", wrCyc[base] - start, 5);
      checkOutput("t5Data", wrData[base], 32'h9900_0000);
    end
    checkOutput("t5RxData", rx_data, 8'h5A);
    checkOutput("t5RxValid", rx_valid, 1);

    $display("[TB] reset mid-transmit");
    uartIdle = 1'b0;
    q0.push_back(8'hE7);
    refreshReq();
    applyStimulus(3);
    checkOutput("t6PreBusy", busy, 1);
    checkOutput("t6PreUartA", uart_a, 2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("t6RstBusy", busy, 0);
    checkOutput("t6RstUartA", uart_a, 1);
    checkOutput("t6RstUartWe", uart_we, 0);
    checkOutput("t6RstUartD", uart_d, 0);
    checkOutput("t6RstTxReady", tx_ready, 0);
    checkOutput("t6RstRxValid", rx_valid, 0);
    checkOutput("t6RstRxData", rx_data, 0);
    #1 rst_n = 1'b1;
    base = wrData.size();
    applyStimulus(20);
    checkOutput("t6NoWrite", wrData.size() - base, 0);
    checkOutput("t6WaitBusy", busy, 1);
    uartIdle = 1'b1;
    start = cyc;
    applyStimulus(5);
    checkOutput("t6WriteCount", wrData.size() - base, 1);
    if (wrData.size() > base) begin
      checkOutput("t6Data", wrData[base], 32'hE700_0000);
      checkOutput("t6Latency", wrCyc[base] - start, 1);
    end

    $display("[TB] three requesters, only req2 valid");
    base = wr3.size();
    txValid3 = 3'b100;
    txData3  = 24'h33_22_11;
    applyStimulus(11);
    txValid3 = 3'b000;
    applyStimulus(6);
    checkOutput("t7WriteCount", wr3.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      if (wr3.size() > base + i) begin
        checkOutput($sformatf("t7Data%0d", i), wr3[base+i], 8'h33);
        checkOutput($sformatf("t7Ready%0d", i), wr3Ready[base+i], 3'b100);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
